alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc_if.sv | 26 ++
 rtl/alu_mc.sv | 219 +++++++++++++++++++++
 tb/tb_alu_mc.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/alu_mc_if.sv
// Handshake and result bundle between an ALU requester and the multi-cycle ALU.
// The requester drives operands and start; the ALU returns status, result and display.
interface alu_mc_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       op;
    logic             start;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Y;
    logic [3:0]       led_flags;
    logic             err;
    logic [6:0]       seg;

    modport master (
        output A, B, op, start,
        input  busy, done, Y, led_flags, err, seg
    );

    modport slave (
        input  A, B, op, start,
        output busy, done, Y, led_flags, err, seg
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle add/sub/logic/shift, iterative shift-add multiply
// and restoring divide, registered result/flags/error and a 7-segment view of Y[3:0].
module alu_mc #(
    parameter int WIDTH = 4
) (
    input  logic     CLK,
    input  logic     RST_N,
    alu_mc_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH:0] SH_LIM = (WIDTH + 1)'(WIDTH);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_reg, state_next;
    logic               busy, done;
    logic [3:0]         op_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [CW-1:0]      cnt_reg;
    logic [2*WIDTH-1:0] acc_reg, acc_next, mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [WIDTH-1:0]   rem_reg, rem_next, quo_reg, quo_next;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH-1:0]   y_reg;
    logic [3:0]         flags_reg;
    logic               err_reg;
    logic [6:0]         seg_val;

    logic               is_iter;
    logic [WIDTH:0]     s_wide;
    logic [WIDTH-1:0]   s_y;
    logic               s_c, s_v, s_err;
    logic [WIDTH-1:0]   m_y;
    logic               m_c;

    function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] y,
                                              input logic c, input logic v);
        return {v, c, (y == '0), y[WIDTH-1]};
    endfunction

    // Divide by zero never iterates; it resolves in one cycle like the simple ops.
    assign is_iter = (bus.op == OP_MUL) ||
                     (((bus.op == OP_DIV) || (bus.op == OP_MOD)) && (bus.B != '0));

    always_ff @(posedge CLK) begin
        if (!RST_N) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = is_iter ? CALC : DONE;
            CALC:    if (cnt_reg == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg != IDLE);
        done = (state_reg == DONE);
    end

    always_comb begin
        s_wide = '0;
        s_y    = '0;
        s_c    = 1'b0;
        s_v    = 1'b0;
        s_err  = 1'b0;
        case (bus.op)
            OP_ADD: begin
                s_wide = {1'b0, bus.A} + {1'b0, bus.B};
                s_y    = s_wide[WIDTH-1:0];
                s_c    = s_wide[WIDTH];
                s_v    = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (s_y[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                // The top bit is the borrow; no borrow means A >= B.
                s_wide = {1'b0, bus.A} - {1'b0, bus.B};
                s_y    = s_wide[WIDTH-1:0];
                s_c    = ~s_wide[WIDTH];
                s_v    = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (s_y[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_MUL: s_y = '0;
            OP_DIV, OP_MOD: begin
                s_y   = '1;
                s_err = 1'b1;
            end
            OP_AND: s_y = bus.A & bus.B;
            OP_OR:  s_y = bus.A | bus.B;
            OP_XOR: s_y = bus.A ^ bus.B;
            OP_SHL: if ({1'b0, bus.B} < SH_LIM) begin
                s_wide = {1'b0, bus.A} << bus.B;
                s_y    = s_wide[WIDTH-1:0];
                s_c    = s_wide[WIDTH];
            end
            OP_SHR: if ({1'b0, bus.B} < SH_LIM) begin
                s_wide = {bus.A, 1'b0} >> bus.B;
                s_y    = s_wide[WIDTH:1];
                s_c    = s_wide[0];
            end
            default: s_err = 1'b1;
        endcase
    end

    always_comb begin
        acc_next  = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
        div_trial = {rem_reg, quo_reg[WIDTH-1]} - {1'b0, b_reg};
        if (!div_trial[WIDTH]) begin
            rem_next = div_trial[WIDTH-1:0];
            quo_next = {quo_reg[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = {rem_reg[WIDTH-2:0], quo_reg[WIDTH-1]};
            quo_next = {quo_reg[WIDTH-2:0], 1'b0};
        end
        m_y = '0;
        m_c = 1'b0;
        case (op_reg)
            OP_MUL: begin
                m_y = acc_next[WIDTH-1:0];
                m_c = |acc_next[2*WIDTH-1:WIDTH];
            end
            OP_DIV:  m_y = quo_next;
            OP_MOD:  m_y = rem_next;
            default: m_y = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            op_reg     <= '0;
            b_reg      <= '0;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            y_reg      <= '0;
            flags_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (bus.start) begin
                    op_reg     <= bus.op;
                    b_reg      <= bus.B;
                    cnt_reg    <= CW'(WIDTH - 1);
                    acc_reg    <= '0;
                    mcand_reg  <= {{WIDTH{1'b0}}, bus.A};
                    mplier_reg <= bus.B;
                    rem_reg    <= '0;
                    quo_reg    <= bus.A;
                    if (!is_iter) begin
                        y_reg     <= s_y;
                        flags_reg <= pack_flags(s_y, s_c, s_v);
                        err_reg   <= s_err;
                    end
                end
                CALC: begin
                    acc_reg    <= acc_next;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    rem_reg    <= rem_next;
                    quo_reg    <= quo_next;
                    cnt_reg    <= cnt_reg - CW'(1);
                    if (cnt_reg == '0) begin
                        y_reg     <= m_y;
                        flags_reg <= pack_flags(m_y, m_c, m_c);
                        err_reg   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    always_comb begin
        seg_val = 7'b1000000;
        case (y_reg[3:0])
            4'h0: seg_val = 7'b1000000;
            4'h1: seg_val = 7'b1111001;
            4'h2: seg_val = 7'b0100100;
            4'h3: seg_val = 7'b0110000;
            4'h4: seg_val = 7'b0011001;
            4'h5: seg_val = 7'b0010010;
            4'h6: seg_val = 7'b0000010;
            4'h7: seg_val = 7'b1111000;
            4'h8: seg_val = 7'b0000000;
            4'h9: seg_val = 7'b0010000;
            4'hA: seg_val = 7'b0001000;
            4'hB: seg_val = 7'b0000011;
            4'hC: seg_val = 7'b1000110;
            4'hD: seg_val = 7'b0100001;
            4'hE: seg_val = 7'b0000110;
            4'hF: seg_val = 7'b0001110;
            default: seg_val = 7'b1000000;
        endcase
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.Y         = y_reg;
    assign bus.led_flags = flags_reg;
    assign bus.err       = err_reg;
    assign bus.seg       = seg_val;
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc at WIDTH=4: directed vector table, randomized ops against an
// arithmetic reference model, and a reset-during-multiply sequence.
module tb_alu_mc;
    localparam int W = 4;
    localparam int M = 1 << W;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(W)) bus ();
    alu_mc #(.WIDTH(W)) dut (.CLK(clk), .RST_N(rst_n), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;
    logic [6:0] seg_tab [16];

    typedef struct {
        int op; int a; int b; int y; int flags; int err; int lat;
    } vec_t;
    vec_t vecs [14];

    function automatic vec_t mk(input int op, input int a, input int b, input int y,
                                input int flags, input int err, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.y = y; v.flags = flags; v.err = err; v.lat = lat;
        return v;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation definitions.
    function automatic void model(input int op, input int a, input int b, output int y,
                                  output int flags, output int err, output int lat);
        int c, v, sa, sb, r, full;
        c = 0; v = 0; err = 0; lat = 1; y = 0;
        sa = (a >= M / 2) ? a - M : a;
        sb = (b >= M / 2) ? b - M : b;
        case (op)
            0: begin
                full = a + b; y = full % M; c = (full >= M) ? 1 : 0;
                r = sa + sb; v = (r < -M / 2 || r >= M / 2) ? 1 : 0;
            end
            1: begin
                full = a - b; y = (full + M) % M; c = (a >= b) ? 1 : 0;
                r = sa - sb; v = (r < -M / 2 || r >= M / 2) ? 1 : 0;
            end
            2: begin
                full = a * b; y = full % M; c = (full >= M) ? 1 : 0; v = c; lat = W + 1;
            end
            3, 4: begin
                if (b == 0) begin y = M - 1; err = 1; end
                else begin y = (op == 3) ? a / b : a % b; lat = W + 1; end
            end
            5: y = a & b;
            6: y = a | b;
            7: y = a ^ b;
            8: if (b < W) begin y = (a << b) % M; c = ((a << b) >> W) & 1; end
            9: if (b < W) begin
                y = a >> b;
                c = (b == 0) ? 0 : ((a >> (b - 1)) & 1);
            end
            default: err = 1;
        endcase
        flags = v * 8 + c * 4 + ((y == 0) ? 2 : 0) + ((y >= M / 2) ? 1 : 0);
    endfunction

    // Called on a falling edge with the DUT idle; returns on the falling edge after done.
    task automatic run_op(input int op, input int a, input int b, input int ey,
                          input int ef, input int ee, input int elat, input string tag);
        int lat;
        bus.op    = op[3:0];
        bus.A     = a[W-1:0];
        bus.B     = b[W-1:0];
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = W'($urandom);
        bus.B     = W'($urandom);
        bus.op    = 4'($urandom);
        lat = 1;
        while (bus.done !== 1'b1 && lat < 40) begin
            bus.start = (lat == 2);
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        check({tag, " latency"}, lat, elat);
        check({tag, " Y"}, int'(bus.Y), ey);
        check({tag, " flags"}, int'(bus.led_flags), ef);
        check({tag, " err"}, int'(bus.err), ee);
        check({tag, " busy_at_done"}, int'(bus.busy), 1);
        check({tag, " seg"}, int'(bus.seg), int'(seg_tab[ey & 15]));
        $display("%s op=%0d A=%0h B=%0h -> Y=%0h flags=%b err=%0d lat=%0d",
                 tag, op, a, b, bus.Y, bus.led_flags, bus.err, lat);
        @(negedge clk);
        check({tag, " done_pulse"}, int'(bus.done), 0);
        check({tag, " idle_busy"}, int'(bus.busy), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int y, f, e, l, op, a, b;
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        vecs[0]  = mk(0, 7, 9, 4'h0, 4'b0110, 0, 1);
        vecs[1]  = mk(0, 7, 1, 4'h8, 4'b1001, 0, 1);
        vecs[2]  = mk(1, 3, 5, 4'hE, 4'b0001, 0, 1);
        vecs[3]  = mk(2, 5, 3, 4'hF, 4'b0001, 0, 5);
        vecs[4]  = mk(2, 6, 3, 4'h2, 4'b1100, 0, 5);
        vecs[5]  = mk(3, 13, 4, 4'h3, 4'b0000, 0, 5);
        vecs[6]  = mk(4, 13, 4, 4'h1, 4'b0000, 0, 5);
        vecs[7]  = mk(3, 9, 0, 4'hF, 4'b0001, 1, 1);
        vecs[8]  = mk(8, 9, 1, 4'h2, 4'b0100, 0, 1);
        vecs[9]  = mk(9, 9, 4, 4'h0, 4'b0010, 0, 1);
        vecs[10] = mk(12, 5, 3, 4'h0, 4'b0010, 1, 1);
        vecs[11] = mk(5, 12, 10, 4'h8, 4'b0001, 0, 1);
        vecs[12] = mk(9, 9, 1, 4'h4, 4'b0100, 0, 1);
        vecs[13] = mk(4, 7, 0, 4'hF, 4'b0001, 1, 1);

        // Reset with a pending start that must be ignored.
        rst_n = 1'b0; bus.start = 1'b1; bus.op = 4'd0; bus.A = 4'd7; bus.B = 4'd9;
        repeat (3) @(negedge clk);
        check("reset busy", int'(bus.busy), 0);
        check("reset done", int'(bus.done), 0);
        check("reset Y", int'(bus.Y), 0);
        check("reset flags", int'(bus.led_flags), 0);
        check("reset err", int'(bus.err), 0);
        check("reset seg", int'(bus.seg), 7'b1000000);
        bus.start = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].flags,
                   vecs[i].err, vecs[i].lat, $sformatf("vec%0d", i));

        for (int i = 0; i < 60; i++) begin
            op = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9);
            a  = $urandom_range(0, M - 1);
            b  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, M - 1);
            model(op, a, b, y, f, e, l);
            run_op(op, a, b, y, f, e, l, $sformatf("rnd%0d", i));
        end

        // Reset in the third CALC cycle of a multiply aborts it without a done.
        run_op(0, 7, 1, 4'h8, 4'b1001, 0, 1, "pre_rst");
        bus.op = 4'd2; bus.A = 4'hF; bus.B = 4'hF; bus.start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            check($sformatf("mul_calc%0d done", c), int'(bus.done), 0);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("abort busy", int'(bus.busy), 0);
        check("abort done", int'(bus.done), 0);
        check("abort Y", int'(bus.Y), 0);
        check("abort flags", int'(bus.led_flags), 0);
        check("abort err", int'(bus.err), 0);
        check("abort seg", int'(bus.seg), 7'b1000000);
        bus.start = 1'b1; bus.op = 4'd0; bus.A = 4'd2; bus.B = 4'd3;
        @(negedge clk);
        check("start_in_reset busy", int'(bus.busy), 0);
        check("start_in_reset done", int'(bus.done), 0);
        rst_n = 1'b1;
        run_op(0, 2, 3, 4'h5, 4'b0000, 0, 1, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
